// File: rtl/chan_mux_scanner.sv
// chan_mux_scanner
//   Registered N-channel selector with a valid/ready output slot.
//   Direct mode (mode=0): captures in_data[sel] every cycle the slot is free.
//   Scan mode (mode=1): a start pulse launches an FSM pass over all channels,
//   one accepted word per channel. The pass runs once, or repeats while cont=1.
//
// Parameters
//   NUM_CH  number of input channels (>= 2)
//   WIDTH   bits per channel
//   SEL_W   channel index width, derived from NUM_CH
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel        direct-mode channel index
//   mode       0 = direct, 1 = scan (only looked at while idle)
//   start      begins a scan pass (mode=1, idle)
//   cont       rescan after the last channel (read at each pass end)
//   out_data   registered selected word
//   out_ch     channel index of out_data
//   out_err    direct-mode sel was out of range at capture
//   out_valid  output slot holds a word
//   out_ready  consumer accepts when out_valid && out_ready
//   busy       FSM is in SCAN
//   out_par    (CHAN_MUX_SCANNER_PARITY_EN only) XOR of out_data bits
//
// Build option
//   Define CHAN_MUX_SCANNER_PARITY_EN to add the out_par output.

module chan_mux_scanner #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    cont,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef CHAN_MUX_SCANNER_PARITY_EN
  output logic                    out_par,
`endif
  output logic                    busy
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  // Channel pick by index compare; an index with no matching channel yields 0,
  // so out-of-range selects never slice past the bus.
  function automatic logic [WIDTH-1:0] pick_ch(input logic [NUM_CH*WIDTH-1:0] bus,
                                               input logic [SEL_W-1:0]        ch);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

`ifdef CHAN_MUX_SCANNER_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  state_t           state, state_d;
  logic [SEL_W-1:0] idx, idx_d;

  logic             cap;
  logic             clr_vld;
  logic [WIDTH-1:0] cap_data;
  logic [SEL_W-1:0] cap_ch;
  logic             cap_err;
  logic             slot_free;

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;
  logic             err_p1;
  logic             vld_p1;
`ifdef CHAN_MUX_SCANNER_PARITY_EN
  logic             par_p1;
`endif

  assign slot_free = !vld_p1 || out_ready;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cap      = 1'b0;
    clr_vld  = 1'b0;
    cap_data = '0;
    cap_ch   = '0;
    cap_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!mode) begin
          if (slot_free) begin
            cap    = 1'b1;
            cap_ch = sel;
            if ({1'b0, sel} >= CH_CNT) begin
              cap_err = 1'b1;
            end else begin
              cap_data = pick_ch(in_data, sel);
            end
          end
        end else begin
          // Scan mode waiting for start: let any accepted word drain out.
          if (slot_free) clr_vld = 1'b1;
          if (start) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          cap      = 1'b1;
          cap_ch   = idx;
          cap_data = pick_ch(in_data, idx);
          if (idx == LAST_CH) begin
            idx_d = '0;
            if (!cont) state_d = IDLE;
          end else begin
            idx_d = idx + SEL_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---- stage p1: output slot register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      data_p1 <= '0;
      ch_p1   <= '0;
      err_p1  <= 1'b0;
      vld_p1  <= 1'b0;
`ifdef CHAN_MUX_SCANNER_PARITY_EN
      par_p1  <= 1'b0;
`endif
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (cap) begin
        data_p1 <= cap_data;
        ch_p1   <= cap_ch;
        err_p1  <= cap_err;
        vld_p1  <= 1'b1;
`ifdef CHAN_MUX_SCANNER_PARITY_EN
        par_p1  <= even_par(cap_data);
`endif
      end else if (clr_vld) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_err   = err_p1;
  assign out_valid = vld_p1;
  assign busy      = (state == SCAN);
`ifdef CHAN_MUX_SCANNER_PARITY_EN
  assign out_par   = par_p1;
`endif

endmodule

// File: doc/chan_mux_scanner.md
Name: chan_mux_scanner

Overview:
- Parametrised, registered N-channel selector. Successor to the combinational 4:1 single-bit select block.
- Direct mode: a registered copy of the channel picked by sel, with a valid/ready output handshake.
- Scan mode: an internal FSM walks every channel in order, one accepted transfer per channel, once or continuously.
- Sits between parallel sample sources and a single serial consumer.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- WIDTH, 4, bits per channel.
- SEL_W, $clog2(NUM_CH), channel index width (derived; not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index, direct mode.
- mode  input  1  0 = direct, 1 = scan; sampled only in IDLE.
- start  input  1  pulse; begins a scan pass when mode=1 and the FSM is in IDLE.
- cont  input  1  1 = wrap and rescan after the last channel; sampled at the end of each pass.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  channel index of out_data.
- out_err  output  1  sel >= NUM_CH at capture (direct mode only).
- out_valid  output  1  out_data/out_ch/out_err are valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- busy  output  1  high in SCAN state.

Behaviour:
- Reset values, applied at the next clk edge with rst_n=0: out_data=0, out_ch=0, out_err=0, out_valid=0, busy=0, FSM=IDLE, scan index=0. Reset mid-scan aborts the pass; pending output is dropped.
- Slot free = !out_valid || out_ready. Captures occur only when the slot is free.
- Backpressure: while out_valid && !out_ready, out_data, out_ch and out_err hold stable and no capture occurs.
- FSM states: IDLE, SCAN.
- IDLE, mode=0 (direct):
  - On every cycle with the slot free, capture in_data[sel] into out_data, sel into out_ch, and set out_valid=1.
  - Latency is 1 cycle from sel/in_data to out_data.
  - If sel >= NUM_CH (non-power-of-2 NUM_CH): out_data=0, out_err=1; otherwise out_err=0.
- IDLE, mode=1: no direct captures. If the slot is free, out_valid clears. start=1 -> SCAN with index=0 and busy=1 on the next cycle.
- IDLE, mode=1, start=1 with slot not free: still enter SCAN; the first capture waits for the slot.
- SCAN:
  - Each cycle with the slot free, capture channel index: out_data=in_data[index], out_ch=index, out_err=0, out_valid=1, then advance index.
  - Capture at index=NUM_CH-1: if cont=1, index wraps to 0 and the FSM stays in SCAN. If cont=0, go to IDLE; busy drops the next cycle; the last word remains valid until accepted.
- SCAN ignores mode, sel and start; a start asserted during SCAN is discarded.
- Data is sampled at capture, not at start. A channel changing mid-pass is seen at its own capture cycle.
- Throughput: one word per cycle when out_ready stays high. A full pass of NUM_CH words takes NUM_CH cycles.

Optional Feature:
- Macro: CHAN_MUX_SCANNER_PARITY_EN.
- Defined: adds output port out_par (1 bit), registered with out_data. out_par = even parity, i.e. the XOR of out_data bits. It resets to 0 and holds under backpressure exactly like out_data.
- Undefined: port absent; no parity logic.

Test Plan:
- NUM_CH=4, WIDTH=4, in_data={4'h8,4'h3,4'hA,4'h5}, mode=0, out_ready=1, sel stepped 3,2,1,0 one per cycle -> out_data 8,3,A,5 with out_ch 3,2,1,0, each appearing one cycle after its sel; out_valid=1 throughout.
- Same in_data, mode=1, start pulse, cont=0, out_ready=1:
  - busy rises the next cycle;
  - out_data 5,A,3,8 with out_ch 0..3 on consecutive cycles;
  - busy falls after ch3; FSM returns to IDLE.
- Scan with out_ready low for 3 cycles while out_ch=1 (4'hA) -> out_data=A and out_ch=1 stay stable for those cycles; no channel is skipped; ch2 follows the first ready cycle.
- Scan with cont=1 for 10 accepted words -> out_ch sequence 0,1,2,3,0,1,2,3,0,1; busy stays 1; cont=0 then ends at ch3.
- NUM_CH=3, mode=0, sel=3 -> out_data=0, out_err=1; then sel=2 -> out_err=0.
- rst_n=0 for one cycle mid-scan at ch2 -> next cycle all outputs 0 and FSM IDLE. A subsequent start rescans from ch0.
